// File: rtl/hazard_controller_if.sv
// Hazard-control bundle between the ID-stage pipeline and hazard_controller.
// master = the controller (drives PC/IF_ID/ID_EX controls); slave = the pipeline side.
interface hazard_controller_if #(
  parameter int PERF_W = 16
);
  logic              IDEX_MemRead_i;
  logic [4:0]        IDEX_RegRt_i;
  logic [4:0]        IFID_RegRs_i;
  logic [4:0]        IFID_RegRt_i;
  logic              Branch_taken_i;
  logic              MulDiv_i;
  logic              PCWrite_o;
  logic              IFIDWrite_o;
  logic              IFIDFlush_o;
  logic              IDEXBubble_o;
  logic              MulDivBusy_o;
  logic [PERF_W-1:0] StallCnt_o;

  modport master (
    input  IDEX_MemRead_i, IDEX_RegRt_i, IFID_RegRs_i, IFID_RegRt_i,
           Branch_taken_i, MulDiv_i,
    output PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXBubble_o,
           MulDivBusy_o, StallCnt_o
  );

  modport slave (
    output IDEX_MemRead_i, IDEX_RegRt_i, IFID_RegRs_i, IFID_RegRt_i,
           Branch_taken_i, MulDiv_i,
    input  PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXBubble_o,
           MulDivBusy_o, StallCnt_o
  );
endinterface

// File: rtl/hazard_controller.sv
// Load-use / branch-flush / mul-div stall sequencer for the 5-stage core.
// Define MULDIV_STALL_EN to compile in the MD_BUSY freeze; otherwise mul/div never stalls.
module hazard_controller #(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 3,
  parameter int PERF_W     = 16
) (
  input  logic                Clock_i,
  input  logic                Reset_n_i,
  hazard_controller_if.master hc
);

  logic              hz;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_bubble;
  logic              md_busy;
  logic [PERF_W-1:0] stall_cnt_d, stall_cnt_q;

  assign hz = hc.IDEX_MemRead_i && (hc.IDEX_RegRt_i != 5'd0) &&
              ((hc.IDEX_RegRt_i == hc.IFID_RegRs_i) ||
               (hc.IDEX_RegRt_i == hc.IFID_RegRt_i));

`ifdef MULDIV_STALL_EN
  typedef enum logic {RUN, MD_BUSY} state_t;

  state_t             state_d, state_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    md_busy     = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;

    if (!Reset_n_i) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (state_q == MD_BUSY) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      md_busy     = 1'b1;
      if (cnt_q == '0) state_d = RUN;
      else             cnt_d   = cnt_q - CNT_W'(1);
    end else if (hz) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (hc.Branch_taken_i) begin
      ifid_flush  = 1'b1;
    end else if (hc.MulDiv_i) begin
      // The issue cycle itself runs normally; MD_BUSY covers the remaining LAT-1 cycles.
      state_d     = MD_BUSY;
      cnt_d       = CNT_W'(MULDIV_LAT - 2);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Clock_i) begin
    if (!Reset_n_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  logic unused_muldiv;
  localparam int unused_cfg = MULDIV_LAT + CNT_W;
  assign unused_muldiv = hc.MulDiv_i;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    md_busy     = 1'b0;
    if (!Reset_n_i || hz) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (hc.Branch_taken_i) begin
      ifid_flush  = 1'b1;
    end
  end
`endif

  // Saturating perf counter: holds at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + PERF_W'(1);
  end

  always_ff @(posedge Clock_i) begin
    if (!Reset_n_i) stall_cnt_q <= '0;
    else            stall_cnt_q <= stall_cnt_d;
  end

  assign hc.PCWrite_o    = pc_write;
  assign hc.IFIDWrite_o  = ifid_write;
  assign hc.IFIDFlush_o  = ifid_flush;
  assign hc.IDEXBubble_o = idex_bubble;
  assign hc.MulDivBusy_o = md_busy;
  assign hc.StallCnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed literal checks plus a randomized run
// compared every cycle against a remaining-busy-cycles / stall-count model.
module tb_hazard_controller;
  localparam int MULDIV_LAT = 4;
  localparam int CNT_W      = 3;
  localparam int PERF_W     = 4;
  localparam int STALL_MAX  = (1 << PERF_W) - 1;
`ifdef MULDIV_STALL_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_controller_if #(.PERF_W(PERF_W)) bus ();

  hazard_controller #(
    .MULDIV_LAT(MULDIV_LAT),
    .CNT_W     (CNT_W),
    .PERF_W    (PERF_W)
  ) dut (
    .Clock_i  (clk),
    .Reset_n_i(rst_n),
    .hc       (bus.master)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int busy_left   = 0;   // busy cycles still owed to the current mul/div
  int stall_model = 0;
  bit model_valid = 1'b0;
  bit exp_pc, exp_ifid, exp_flush, exp_bub, exp_busy, issue;

  always @(negedge clk) begin
    bit hz_m;
    hz_m = bus.IDEX_MemRead_i && (bus.IDEX_RegRt_i != 0) &&
           (bus.IDEX_RegRt_i == bus.IFID_RegRs_i || bus.IDEX_RegRt_i == bus.IFID_RegRt_i);
    exp_pc = 1; exp_ifid = 1; exp_flush = 0; exp_bub = 0; exp_busy = 0; issue = 0;
    if (!rst_n) begin
      exp_pc = 0; exp_ifid = 0; exp_bub = 1;
    end else if (busy_left > 0) begin
      exp_pc = 0; exp_ifid = 0; exp_bub = 1; exp_busy = 1;
    end else if (hz_m) begin
      exp_pc = 0; exp_ifid = 0; exp_bub = 1;
    end else if (bus.Branch_taken_i) begin
      exp_flush = 1;
    end else if (bus.MulDiv_i && MD_EN) begin
      issue = 1;
    end
    if (model_valid) begin
      check("model_pcwrite",   int'(bus.PCWrite_o),    int'(exp_pc));
      check("model_ifidwrite", int'(bus.IFIDWrite_o),  int'(exp_ifid));
      check("model_flush",     int'(bus.IFIDFlush_o),  int'(exp_flush));
      check("model_bubble",    int'(bus.IDEXBubble_o), int'(exp_bub));
      check("model_busy",      int'(bus.MulDivBusy_o), int'(exp_busy));
      check("model_stallcnt",  int'(bus.StallCnt_o),   stall_model);
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      busy_left   = 0;
      stall_model = 0;
      model_valid = 1'b1;
    end else begin
      if (!exp_pc && stall_model < STALL_MAX) stall_model++;
      if (busy_left > 0) busy_left--;
      else if (issue)    busy_left = MULDIV_LAT - 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit rn, input bit mr, input int rt_ex, input int rs_id,
                       input int rt_id, input bit br, input bit md);
    @(posedge clk);
    #1;
    rst_n              = rn;
    bus.IDEX_MemRead_i = mr;
    bus.IDEX_RegRt_i   = 5'(rt_ex);
    bus.IFID_RegRs_i   = 5'(rs_id);
    bus.IFID_RegRt_i   = 5'(rt_id);
    bus.Branch_taken_i = br;
    bus.MulDiv_i       = md;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.IDEX_MemRead_i = 0; bus.IDEX_RegRt_i = 0; bus.IFID_RegRs_i = 0;
    bus.IFID_RegRt_i = 0; bus.Branch_taken_i = 0; bus.MulDiv_i = 0;

    // Reset: outputs forced while asserted
    drive(0, 0, 0, 0, 0, 0, 1);
    check("rst_pcwrite", int'(bus.PCWrite_o), 0);
    check("rst_bubble",  int'(bus.IDEXBubble_o), 1);
    check("rst_busy",    int'(bus.MulDivBusy_o), 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    check("idle_pcwrite", int'(bus.PCWrite_o), 1);
    check("rst_stallcnt", int'(bus.StallCnt_o), 0);

    // Load-use, then r0 destination must not stall
    drive(1, 1, 5, 5, 0, 0, 0);
    check("lu_pcwrite",   int'(bus.PCWrite_o), 0);
    check("lu_ifidwrite", int'(bus.IFIDWrite_o), 0);
    check("lu_bubble",    int'(bus.IDEXBubble_o), 1);
    drive(1, 1, 0, 0, 0, 0, 0);
    check("r0_pcwrite",   int'(bus.PCWrite_o), 1);
    check("lu_stallcnt",  int'(bus.StallCnt_o), 1);

    // Branch vs hazard: hazard wins, then flush
    drive(1, 1, 7, 0, 7, 1, 0);
    check("brhz_flush",   int'(bus.IFIDFlush_o), 0);
    check("brhz_pcwrite", int'(bus.PCWrite_o), 0);
    drive(1, 0, 7, 0, 7, 1, 0);
    check("br_flush",     int'(bus.IFIDFlush_o), 1);
    check("br_pcwrite",   int'(bus.PCWrite_o), 1);
    check("br_stallcnt",  int'(bus.StallCnt_o), 2);

`ifdef MULDIV_STALL_EN
    // Mul/div latency 4: issue cycle, 3 busy cycles (inputs ignored), then RUN
    drive(1, 0, 0, 0, 0, 0, 1);
    check("md_issue_pc", int'(bus.PCWrite_o), 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 3, 3, 3, 1, 1);
      check("md_busy",    int'(bus.MulDivBusy_o), 1);
      check("md_pcwrite", int'(bus.PCWrite_o), 0);
      check("md_flush",   int'(bus.IFIDFlush_o), 0);
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    check("md_done_busy", int'(bus.MulDivBusy_o), 0);
    check("md_done_pc",   int'(bus.PCWrite_o), 1);
    check("md_stallcnt",  int'(bus.StallCnt_o), 5);
    // Reset mid-op
    drive(1, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0);
    check("mid_busy", int'(bus.MulDivBusy_o), 1);
`else
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 0, 0, 1);
      check("nomd_pcwrite", int'(bus.PCWrite_o), 1);
      check("nomd_busy",    int'(bus.MulDivBusy_o), 0);
    end
    check("nomd_stallcnt", int'(bus.StallCnt_o), 2);
`endif
    drive(0, 0, 0, 0, 0, 0, 0);
    check("midrst_busy", int'(bus.MulDivBusy_o), 0);
    check("midrst_pc",   int'(bus.PCWrite_o), 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    check("post_rst_busy", int'(bus.MulDivBusy_o), 0);
    check("post_rst_pc",   int'(bus.PCWrite_o), 1);
    check("post_rst_cnt",  int'(bus.StallCnt_o), 0);

    // Saturation: 20 stall cycles on a 4-bit counter
    for (int i = 0; i < 20; i++) drive(1, 1, 9, 0, 9, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    check("sat_stallcnt", int'(bus.StallCnt_o), 15);
    drive(1, 1, 9, 9, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    check("sat_hold", int'(bus.StallCnt_o), 15);

    // Randomized run, checked by the model each cycle
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 59) != 0,
            $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)),
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 4) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
